// File: rtl/branch_sequencer_pkg.sv
// rtl/branch_sequencer_pkg.sv - shared constants and state encoding for the branch sequencer
package branch_sequencer_pkg;

    // Condition codes driven toward the CON evaluator
    localparam logic [1:0] C2_ZERO    = 2'd0;
    localparam logic [1:0] C2_NONZERO = 2'd1;
    localparam logic [1:0] C2_POS     = 2'd2;
    localparam logic [1:0] C2_NEG     = 2'd3;

    // Instruction field positions
    localparam int IR_OP_HI = 31;
    localparam int IR_OP_LO = 27;
    localparam int IR_RA_HI = 26;
    localparam int IR_RA_LO = 23;
    localparam int IR_C2_HI = 20;
    localparam int IR_C2_LO = 19;

    // Opcode of a conditional branch
    localparam logic [4:0] BR_OPCODE = 5'b10011;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EVAL   = 2'd1,
        ST_UPDATE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/branch_sequencer_if.sv
// rtl/branch_sequencer_if.sv - control/datapath bundle of the branch sequencer (stats ports under BRANCH_STATS_EN)
interface branch_sequencer_if #(
    parameter int PC_W = 32
);
    logic            start;
    logic [31:0]     ir;
    logic            pc_inc;
    logic            con_in;
    logic [1:0]      c2_out;
    logic [3:0]      ra_out;
    logic            reg_rd;
    logic [PC_W-1:0] pc;
    logic            busy;
    logic            done;
    logic            taken;
    logic            illegal;
`ifdef BRANCH_STATS_EN
    logic [15:0]     taken_cnt;
    logic [15:0]     not_taken_cnt;
`endif

    // Control unit / evaluator side
    modport master (
        output start, ir, pc_inc, con_in,
        input  c2_out, ra_out, reg_rd, pc, busy, done, taken, illegal
`ifdef BRANCH_STATS_EN
        , input taken_cnt, not_taken_cnt
`endif
    );

    // Sequencer side
    modport slave (
        input  start, ir, pc_inc, con_in,
        output c2_out, ra_out, reg_rd, pc, busy, done, taken, illegal
`ifdef BRANCH_STATS_EN
        , output taken_cnt, not_taken_cnt
`endif
    );

endinterface

// File: rtl/branch_stats.sv
// rtl/branch_stats.sv - saturating taken / not-taken completion counters
module branch_stats (
    input  logic        clock,
    input  logic        clear,
    input  logic        done,
    input  logic        taken,
    output logic [15:0] taken_cnt,
    output logic [15:0] not_taken_cnt
);

    // Count each completion once; illegal completions arrive with taken=0
    always_ff @(posedge clock) begin
        if (clear) begin
            taken_cnt     <= 16'h0000;
            not_taken_cnt <= 16'h0000;
        end else if (done) begin
            if (taken) begin
                if (taken_cnt != 16'hFFFF)
                    taken_cnt <= taken_cnt + 16'h0001;
            end else begin
                if (not_taken_cnt != 16'hFFFF)
                    not_taken_cnt <= not_taken_cnt + 16'h0001;
            end
        end
    end

endmodule

// File: rtl/branch_sequencer.sv
// rtl/branch_sequencer.sv - multi-cycle conditional branch resolver and PC owner (optional BRANCH_STATS_EN counters)
module branch_sequencer
    import branch_sequencer_pkg::*;
#(
    parameter int         PC_W      = 32,
    parameter int         OFF_W     = 19,
    parameter logic [4:0] BR_OPCODE = branch_sequencer_pkg::BR_OPCODE
) (
    input logic               clock,
    input logic               clear,
    branch_sequencer_if.slave bus
);

    state_t            state;
    logic [PC_W-1:0]   pc_q;
    logic [OFF_W-1:0]  off_q;
    logic              match_q;
    logic              con_q;
    logic [1:0]        c2_q;
    logic [3:0]        ra_q;
    logic              done_q;
    logic              taken_q;
    logic              illegal_q;
    logic [PC_W-1:0]   off_sext;

    assign off_sext = {{(PC_W-OFF_W){off_q[OFF_W-1]}}, off_q};

    // Sequencer FSM with PC register and registered completion outputs
    always_ff @(posedge clock) begin
        if (clear) begin
            state     <= ST_IDLE;
            pc_q      <= '0;
            off_q     <= '0;
            match_q   <= 1'b0;
            con_q     <= 1'b0;
            c2_q      <= 2'b00;
            ra_q      <= 4'h0;
            done_q    <= 1'b0;
            taken_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // start takes priority; a coincident increment is dropped
                    if (bus.start) begin
                        c2_q    <= bus.ir[IR_C2_HI:IR_C2_LO];
                        ra_q    <= bus.ir[IR_RA_HI:IR_RA_LO];
                        off_q   <= bus.ir[OFF_W-1:0];
                        match_q <= (bus.ir[IR_OP_HI:IR_OP_LO] == BR_OPCODE);
                        state   <= ST_EVAL;
                    end else if (bus.pc_inc) begin
                        pc_q <= pc_q + {{(PC_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_EVAL: begin
                    // Non-branch opcodes can never be taken
                    con_q <= bus.con_in & match_q;
                    state <= ST_UPDATE;
                end
                ST_UPDATE: begin
                    if (con_q)
                        pc_q <= pc_q + off_sext;
                    done_q    <= 1'b1;
                    taken_q   <= con_q;
                    illegal_q <= ~match_q;
                    state     <= ST_DONE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.c2_out  = c2_q;
    assign bus.ra_out  = ra_q;
    assign bus.reg_rd  = (state == ST_EVAL);
    assign bus.busy    = (state != ST_IDLE);
    assign bus.pc      = pc_q;
    assign bus.done    = done_q;
    assign bus.taken   = taken_q;
    assign bus.illegal = illegal_q;

`ifdef BRANCH_STATS_EN
    branch_stats u_stats (
        .clock         (clock),
        .clear         (clear),
        .done          (done_q),
        .taken         (taken_q),
        .taken_cnt     (bus.taken_cnt),
        .not_taken_cnt (bus.not_taken_cnt)
    );
`endif

endmodule

// File: tb/tb_branch_sequencer.sv
// tb/tb_branch_sequencer.sv - scoreboard bench for branch_sequencer (BRANCH_STATS_EN adds counter checks)
module tb_branch_sequencer;
    import branch_sequencer_pkg::*;

    logic clock = 1'b0;
    logic clear;

    always #5 clock = ~clock;

    branch_sequencer_if #(.PC_W(32)) bus ();

    branch_sequencer #(.PC_W(32), .OFF_W(19), .BR_OPCODE(5'b10011)) dut (
        .clock (clock),
        .clear (clear),
        .bus   (bus)
    );

    typedef struct {
        logic        taken;
        logic        illegal;
        logic [31:0] pc;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest expected completion
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (bus.done === 1'b1) begin
                if (sb.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_done: got done=1 expected done=0");
                end else begin
                    e = sb.pop_front();
                    check("done_taken", {31'b0, bus.taken}, {31'b0, e.taken});
                    check("done_illegal", {31'b0, bus.illegal}, {31'b0, e.illegal});
                    check("done_pc", bus.pc, e.pc);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic inc_n(input int n);
        bus.pc_inc = 1'b1;
        repeat (n) tick();
        bus.pc_inc = 1'b0;
    endtask

    function automatic logic [31:0] mk_ir(input logic [4:0] op, input logic [3:0] ra,
                                          input logic [1:0] c2, input logic [18:0] off);
        return {op, ra, 2'b00, c2, off};
    endfunction

    // One full branch; poke drives start/pc_inc while busy to prove they are ignored
    task automatic branch(input string tag, input logic [31:0] instr, input logic con,
                          input logic inc_too, input logic poke, input logic [31:0] start_pc,
                          input logic exp_taken, input logic exp_ill, input logic [31:0] exp_pc);
        exp_t e;
        e.taken = exp_taken; e.illegal = exp_ill; e.pc = exp_pc;
        sb.push_back(e);
        bus.ir     = instr;
        bus.start  = 1'b1;
        bus.pc_inc = inc_too;
        tick();                                   // EVAL
        bus.start  = poke;
        bus.pc_inc = poke;
        bus.con_in = con;
        check({tag, "_eval_reg_rd"}, {31'b0, bus.reg_rd}, 32'd1);
        check({tag, "_eval_busy"}, {31'b0, bus.busy}, 32'd1);
        check({tag, "_eval_c2"}, {30'b0, bus.c2_out}, {30'b0, instr[20:19]});
        check({tag, "_eval_ra"}, {28'b0, bus.ra_out}, {28'b0, instr[26:23]});
        check({tag, "_eval_pc"}, bus.pc, start_pc);
        tick();                                   // UPDATE
        bus.con_in = 1'b0;
        check({tag, "_upd_reg_rd"}, {31'b0, bus.reg_rd}, 32'd0);
        check({tag, "_upd_done"}, {31'b0, bus.done}, 32'd0);
        tick();                                   // DONE
        bus.start  = 1'b0;
        bus.pc_inc = 1'b0;
        check({tag, "_done_at_k3"}, {31'b0, bus.done}, 32'd1);
        check({tag, "_done_busy"}, {31'b0, bus.busy}, 32'd1);
        tick();                                   // IDLE
        check({tag, "_idle_done"}, {31'b0, bus.done}, 32'd0);
        check({tag, "_idle_busy"}, {31'b0, bus.busy}, 32'd0);
    endtask

    initial begin
        bus.start  = 1'b0;
        bus.ir     = 32'h0;
        bus.pc_inc = 1'b0;
        bus.con_in = 1'b0;
        clear      = 1'b1;
        tick();
        do_reset();

        // Reset state
        check("rst_pc", bus.pc, 32'h0);
        check("rst_busy", {31'b0, bus.busy}, 32'd0);
        check("rst_done", {31'b0, bus.done}, 32'd0);
        check("rst_reg_rd", {31'b0, bus.reg_rd}, 32'd0);
        check("rst_c2", {30'b0, bus.c2_out}, 32'd0);
        check("rst_ra", {28'b0, bus.ra_out}, 32'd0);
        check("rst_taken", {31'b0, bus.taken}, 32'd0);
        check("rst_illegal", {31'b0, bus.illegal}, 32'd0);

        // Taken branch: 0x10 + 5
        inc_n(16);
        check("inc16_pc", bus.pc, 32'h10);
        branch("taken", mk_ir(5'b10011, 4'h3, C2_ZERO, 19'd5), 1'b1, 1'b0, 1'b0,
               32'h10, 1'b1, 1'b0, 32'h15);

        // Not-taken branch from 0x10
        do_reset();
        inc_n(16);
        branch("nottaken", mk_ir(5'b10011, 4'hA, C2_NONZERO, 19'd5), 1'b0, 1'b0, 1'b0,
               32'h10, 1'b0, 1'b0, 32'h10);

        // Negative offset wraps below zero, then increment wraps above
        do_reset();
        inc_n(2);
        check("inc2_pc", bus.pc, 32'h2);
        branch("negwrap", mk_ir(5'b10011, 4'h7, C2_POS, 19'h7FFFD), 1'b1, 1'b0, 1'b0,
               32'h2, 1'b1, 1'b0, 32'hFFFFFFFF);
        inc_n(1);
        check("inc_wrap_pc", bus.pc, 32'h0);

        // Illegal opcode forces not-taken even with CON high
        branch("illegal", mk_ir(5'b00000, 4'h1, C2_POS, 19'd7), 1'b1, 1'b0, 1'b0,
               32'h0, 1'b0, 1'b1, 32'h0);

        // start and pc_inc together: increment dropped, pc = 0 + 4
        branch("collide", mk_ir(5'b10011, 4'h2, C2_NEG, 19'd4), 1'b1, 1'b1, 1'b0,
               32'h0, 1'b1, 1'b0, 32'h4);

        // start/pc_inc while busy are ignored; exactly one done
        branch("poke", mk_ir(5'b10011, 4'h5, C2_NEG, 19'd9), 1'b0, 1'b0, 1'b1,
               32'h4, 1'b0, 1'b0, 32'h4);
        tick();
        tick();
        check("poke_after_busy", {31'b0, bus.busy}, 32'd0);
        check("poke_after_pc", bus.pc, 32'h4);

`ifdef BRANCH_STATS_EN
        check("stats_taken", {16'b0, bus.taken_cnt}, 32'd2);
        check("stats_not_taken", {16'b0, bus.not_taken_cnt}, 32'd2);
`endif

        // Clear asserted during UPDATE abandons the branch
        bus.ir     = mk_ir(5'b10011, 4'h6, C2_ZERO, 19'd1);
        bus.start  = 1'b1;
        tick();                                   // EVAL
        bus.start  = 1'b0;
        bus.con_in = 1'b1;
        tick();                                   // UPDATE
        bus.con_in = 1'b0;
        check("mid_upd_busy", {31'b0, bus.busy}, 32'd1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("mid_rst_busy", {31'b0, bus.busy}, 32'd0);
        check("mid_rst_done", {31'b0, bus.done}, 32'd0);
        check("mid_rst_pc", bus.pc, 32'h0);
        check("mid_rst_reg_rd", {31'b0, bus.reg_rd}, 32'd0);
        check("mid_rst_taken", {31'b0, bus.taken}, 32'd0);
`ifdef BRANCH_STATS_EN
        check("mid_rst_taken_cnt", {16'b0, bus.taken_cnt}, 32'd0);
        check("mid_rst_not_taken_cnt", {16'b0, bus.not_taken_cnt}, 32'd0);
`endif
        repeat (4) tick();
        check("mid_rst_idle_pc", bus.pc, 32'h0);

        check("sb_drained", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
